// File: rtl/z80_io_pkg.sv
// +--------------------------------------------------------------------+
// | z80_io_pkg : shared encodings for the Z80 I/O peripheral slice      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package z80_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam logic [7:0] DEFAULT_DATA_PORT   = 8'h00;
  localparam logic [7:0] DEFAULT_STATUS_PORT = 8'h01;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/z80_io_uart_tx_sync_fifo.sv
// +--------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, depth 2**AW               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/z80_io_uart_tx.sv
// +--------------------------------------------------------------------+
// | z80_io_uart_tx : I/O-mapped FIFO-buffered 8N1 UART transmitter      |
// | Optional even parity bit with macro UART_TX_PARITY_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module z80_io_uart_tx
  import z80_io_pkg::*;
#(
  parameter int         CLK_HZ      = 1000000,
  parameter int         BAUD        = 9600,
  parameter logic [7:0] DATA_PORT   = DEFAULT_DATA_PORT,
  parameter logic [7:0] STATUS_PORT = DEFAULT_STATUS_PORT,
  parameter int         FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] address,
  input  logic [7:0] dbus_out,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  output logic [7:0] dbus_in,
  output logic       dbus_oe,
  output logic       tx,
  output logic [7:0] last_char
);

  localparam int               DIV         = CLK_HZ / BAUD;
  localparam int               CNT_W       = $clog2(DIV);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);

  logic               wr_hit, wr_hit_q, wr_hit_d;
  logic               rd_hit_q, rd_hit_d;
  logic               push_req, push_ok, rd_rise;
  logic               ovf_q, ovf_d;
  logic [7:0]         last_char_q, last_char_d;

  logic               fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [7:0]         fifo_dout;
  logic [FIFO_AW:0]   fifo_count;

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_q, bit_d;
  logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [7:0]         status;

  assign wr_hit  = ~iorq_n & ~wr_n & (address == DATA_PORT);
  assign dbus_oe = ~iorq_n & ~rd_n & (address == STATUS_PORT);

  // One push per OUT: only the leading edge of the write hit counts.
  assign push_req = wr_hit & ~wr_hit_q;
  assign push_ok  = push_req & (~fifo_full | fifo_pop);
  assign rd_rise  = dbus_oe & ~rd_hit_q;

  always_comb begin
    wr_hit_d    = wr_hit;
    rd_hit_d    = dbus_oe;
    last_char_d = push_ok ? dbus_out : last_char_q;
    ovf_d       = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (rd_rise)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_hit_q    <= 1'b0;
      rd_hit_q    <= 1'b0;
      ovf_q       <= 1'b0;
      last_char_q <= 8'h00;
    end else begin
      wr_hit_q    <= wr_hit_d;
      rd_hit_q    <= rd_hit_d;
      ovf_q       <= ovf_d;
      last_char_q <= last_char_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   (dbus_out),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                          = 8'h00;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_FULL]               = fifo_full;
    status[STAT_BUSY]               = (state_q != ST_IDLE);
    status[STAT_OVF]                = ovf_q;
    status[STAT_COUNT_LSB +: 4]     = 4'(fifo_count);
  end

  assign dbus_in   = dbus_oe ? status : 8'h00;
  assign tx        = tx_q;
  assign last_char = last_char_q;

  // Every bit period ends when the counter hits zero; it reloads on the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = BAUD_RELOAD;
          bit_d    = 3'd0;
          tx_d     = 1'b0;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d    = even_parity(fifo_dout);
`endif
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = BAUD_RELOAD;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          cnt_d   = BAUD_RELOAD;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z80_io_uart_tx.sv
// +--------------------------------------------------------------------+
// | tb_z80_io_uart_tx : scoreboard bench for z80_io_uart_tx (DIV = 4)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_z80_io_uart_tx;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * DIV;
  localparam logic [7:0] DPORT = 8'h00;
  localparam logic [7:0] SPORT = 8'h01;

  logic       clk, rst_n;
  logic [7:0] address, dbus_out, dbus_in, last_char;
  logic       iorq_n, wr_n, rd_n, dbus_oe, tx;

  z80_io_uart_tx #(
    .CLK_HZ      (1000000),
    .BAUD        (250000),
    .DATA_PORT   (DPORT),
    .STATUS_PORT (SPORT),
    .FIFO_AW     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .dbus_out  (dbus_out),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .dbus_in   (dbus_in),
    .dbus_oe   (dbus_oe),
    .tx        (tx),
    .last_char (last_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  always @(posedge clk) cyc++;

  logic [7:0] frame_q[$];
  logic [7:0] stat_q[$];
  int         start_stamp[$];
  int         frames_done = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[NBITS-1] = 1'b1;
    return f;
  endfunction

  // Frame monitor: decodes each start bit and checks every cycle of the frame.
  bit               mon_active = 1'b0;
  bit               mon_unexp;
  bit               mon_err;
  int               mon_cyc;
  int               err_cyc;
  logic [7:0]       mon_byte;
  logic [NBITS-1:0] mon_bits;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      frame_q.delete();
    end else begin
      if (!mon_active && tx === 1'b0) begin
        start_stamp.push_back(cyc);
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_err    = 1'b0;
        mon_unexp  = (frame_q.size() == 0);
        if (mon_unexp) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", cyc);
        end else begin
          mon_byte = frame_q.pop_front();
          mon_bits = frame_bits(mon_byte);
        end
      end
      if (mon_active) begin
        if (!mon_unexp && !mon_err && tx !== mon_bits[mon_cyc / DIV]) begin
          mon_err = 1'b1;
          err_cyc = mon_cyc;
        end
        mon_cyc++;
        if (mon_cyc == FRAME_LEN) begin
          mon_active = 1'b0;
          frames_done++;
          if (!mon_unexp) begin
            vectors++;
            if (mon_err) begin
              miscompares++;
              $display("FAIL frame_%02h: tx wrong at frame cycle %0d, got %b, expected %b",
                       mon_byte, err_cyc, !mon_bits[err_cyc / DIV], mon_bits[err_cyc / DIV]);
            end
          end
        end
      end
    end
  end

  // Status monitor: compares the byte on the first cycle of every STATUS read.
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (dbus_oe && !oe_prev) begin
      if (stat_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_status_read: got %02h, expected no read", dbus_in);
      end else begin
        check("status", int'(dbus_in), int'(stat_q.pop_front()));
      end
    end
    oe_prev = dbus_oe;
  end

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    address  = a;
    dbus_out = d;
    iorq_n   = 1'b0;
    wr_n     = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    iorq_n = 1'b1;
    wr_n   = 1'b1;
  endtask

  task automatic status_read(input logic [7:0] exp);
    stat_q.push_back(exp);
    @(posedge clk); #1;
    address = SPORT;
    iorq_n  = 1'b0;
    rd_n    = 1'b0;
    @(posedge clk); #1;
    iorq_n  = 1'b1;
    rd_n    = 1'b1;
    address = 8'h00;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, frames_done, target);
  endtask

  initial begin
    int n;
    rst_n    = 1'b1;
    iorq_n   = 1'b1;
    wr_n     = 1'b1;
    rd_n     = 1'b1;
    address  = 8'h00;
    dbus_out = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_dbus_in", int'(dbus_in), 0);
    check("reset_dbus_oe", int'(dbus_oe), 0);
    check("reset_last_char", int'(last_char), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    status_read(8'h01);

    // Single OUT with a 3-cycle strobe, then fill behind it while A5 is on the wire.
    frame_q.push_back(8'hA5);
    io_write(DPORT, 8'hA5, 3);
    @(negedge clk);
    check("last_char_a5", int'(last_char), 'hA5);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) frame_q.push_back(8'(i));
      io_write(DPORT, 8'(i), 1);
    end
    @(negedge clk);
    check("last_char_after_drop", int'(last_char), 'h07);
    status_read(8'h8E);
    status_read(8'h86);

    wait_frames(9, "drain_frames");
    for (int i = 1; i < 9 && i < start_stamp.size(); i++)
      check($sformatf("frame_gap_%0d", i), start_stamp[i] - start_stamp[i-1], FRAME_LEN + 1);
    status_read(8'h01);

    // Reset while a data bit of 0 is on the line.
    frame_q.push_back(8'h3C);
    io_write(DPORT, 8'h3C, 1);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_3c_seen", int'(tx), 0);
    repeat (2 * DIV + 1) @(negedge clk);
    check("tx_mid_data_3c", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1 check("tx_async_reset", int'(tx), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("last_char_after_reset", int'(last_char), 0);
    status_read(8'h01);
    repeat (100) @(negedge clk);
    check("tx_idle_after_reset", int'(tx), 1);
    check("frames_after_reset", frames_done, 9);

`ifdef UART_TX_PARITY_EN
    frame_q.push_back(8'h07);
    io_write(DPORT, 8'h07, 1);
    frame_q.push_back(8'h03);
    io_write(DPORT, 8'h03, 1);
    wait_frames(11, "parity_frames");
    if (start_stamp.size() >= 12)
      check("parity_frame_gap", start_stamp[11] - start_stamp[10], 45);
    else
      check("parity_start_count", start_stamp.size(), 12);
`endif

    repeat (4) @(negedge clk);
    check("frames_left", frame_q.size(), 0);
    check("status_left", stat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
